// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter. Serialises a 48-bit SD command frame
// (start, transmit, index, argument, CRC7, end) on the falling edges of
// sd_clk, then holds CMD released for TRAIL_CLKS sd_clk falls before
// reporting done. All logic runs on clk; sd_clk is treated as data.
module sd_cmd_tx #(
  parameter int unsigned TRAIL_CLKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_clk,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        ready,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, SHIFT, TRAIL} state_e;

  // Terminal value of the trailer counter; unused when TRAIL_CLKS is 0.
  localparam logic [15:0] TRAIL_LAST = (TRAIL_CLKS == 0) ? 16'd0 : 16'(TRAIL_CLKS - 1);

  state_e      state_q, state_d;
  logic        sd_clk_q;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] trail_cnt_q, trail_cnt_d;
  logic        cmd_out_q, cmd_out_d;
  logic        cmd_oe_q, cmd_oe_d;
  logic        done_q, done_d;

  logic        fall;
  logic [39:0] frame_hi;
  logic [5:0]  next_bit;

  // One serial step of CRC7 with polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
    logic fb;
    fb = d ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  // Value of frame bit n; CRC bits come from the running CRC, which already
  // covers bits 47..8 by the time bit 7 is selected.
  function automatic logic frame_bit(input logic [5:0] n, input logic [39:0] hi,
                                     input logic [6:0] crc);
    if (n >= 6'd8)      return hi[n - 6'd8];
    else if (n != 6'd0) return crc[n[2:0] - 3'd1];
    else                return 1'b1;
  endfunction

  assign fall     = sd_clk_q & ~sd_clk;
  assign frame_hi = {2'b01, idx_q, arg_q};
  assign next_bit = bit_cnt_q - 6'd1;

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign cmd_out = cmd_out_q;
  assign cmd_oe  = cmd_oe_q;

  // State and datapath registers; reset releases CMD immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sd_clk_q    <= 1'b0;
      idx_q       <= '0;
      arg_q       <= '0;
      crc_q       <= '0;
      bit_cnt_q   <= '0;
      trail_cnt_q <= '0;
      cmd_out_q   <= 1'b1;
      cmd_oe_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sd_clk_q    <= sd_clk;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      crc_q       <= crc_d;
      bit_cnt_q   <= bit_cnt_d;
      trail_cnt_q <= trail_cnt_d;
      cmd_out_q   <= cmd_out_d;
      cmd_oe_q    <= cmd_oe_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: every step is gated by an sd_clk fall event.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    crc_d       = crc_q;
    bit_cnt_d   = bit_cnt_q;
    trail_cnt_d = trail_cnt_q;
    cmd_out_d   = cmd_out_q;
    cmd_oe_d    = cmd_oe_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_oe_d  = 1'b0;
        cmd_out_d = 1'b1;
        if (start) begin
          idx_d     = cmd_index;
          arg_d     = argument;
          crc_d     = '0;
          bit_cnt_d = '0;
          state_d   = WAIT_EDGE;
        end
      end

      WAIT_EDGE: begin
        if (fall) begin
          cmd_oe_d  = 1'b1;
          cmd_out_d = frame_bit(6'd47, frame_hi, crc_q);
          crc_d     = crc7_step(crc_q, frame_bit(6'd47, frame_hi, crc_q));
          bit_cnt_d = 6'd47;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (fall) begin
          if (bit_cnt_q == 6'd0) begin
            cmd_oe_d    = 1'b0;
            cmd_out_d   = 1'b1;
            trail_cnt_d = '0;
            if (TRAIL_CLKS == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = TRAIL;
            end
          end else begin
            cmd_out_d = frame_bit(next_bit, frame_hi, crc_q);
            if (next_bit >= 6'd8) begin
              crc_d = crc7_step(crc_q, frame_bit(next_bit, frame_hi, crc_q));
            end
            bit_cnt_d = next_bit;
          end
        end
      end

      TRAIL: begin
        if (fall) begin
          if (trail_cnt_q == TRAIL_LAST) begin
            trail_cnt_d = '0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end else begin
            trail_cnt_d = trail_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/sd_cmd_tx.md
SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 Parameter TRAIL_CLKS, default 8, number of sd_clk falling edges with CMD released after the stop bit (Ncc).
REQ-002 clk  input  1  system clock; all logic rising-edge clk only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sd_clk  input  1  divided SD clock from the clock-divider stage, generated in the clk domain.
REQ-005 start  input  1  command request, qualified by ready.
REQ-006 cmd_index  input  6  SD command index.
REQ-007 argument  input  32  command argument.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done  output  1  one-clk pulse at end of command plus trailer.
REQ-010 cmd_out  output  1  serial CMD line data.
REQ-011 cmd_oe  output  1  CMD line output enable; 0 means released (pull-up high).

Function
REQ-012 The block SHALL register sd_clk once per clk and detect a falling edge as previous=1, current=0; all bit timing SHALL be counted in these fall events only.
REQ-013 States SHALL be IDLE, WAIT_EDGE, SHIFT, TRAIL.
REQ-014 ready SHALL be 1 exactly when state is IDLE.
REQ-015 In IDLE: cmd_oe=0, cmd_out=1.
REQ-016 start with ready=1 SHALL latch cmd_index and argument in that clk cycle and move to WAIT_EDGE; start with ready=0 SHALL be ignored.
REQ-017 Frame SHALL be 48 bits MSB first: bit47=0 (start), bit46=1 (transmit), bits45:40=cmd_index, bits39:8=argument, bits7:1=CRC7, bit0=1 (end).
REQ-018 CRC7 SHALL use polynomial x^7+x^3+1, initial value 0, over frame bits 47..8 in transmit order; computation completes before bit 7 is driven.
REQ-019 WAIT_EDGE: on the first fall event, cmd_oe=1, cmd_out=bit47, go to SHIFT with bit counter 47.
REQ-020 SHIFT: each fall event SHALL advance exactly one bit; bit N held stable for one full sd_clk period.
REQ-021 On the fall event after bit0 has been driven, cmd_oe=0, cmd_out=1, trailer counter cleared, go to TRAIL.
REQ-022 TRAIL: count fall events; on the TRAIL_CLKS-th, go to IDLE and assert done for exactly that one following clk cycle (done registered, coincident with first IDLE cycle).
REQ-023 start in the cycle done=1 SHALL be accepted (ready is already 1).
REQ-024 TRAIL_CLKS=0 SHALL go directly from stop-bit release to IDLE with done on the same fall event.
REQ-025 Latched command fields SHALL not change while state is not IDLE regardless of input activity.
REQ-026 If sd_clk stops toggling, the block SHALL hold its current state and outputs indefinitely; no timeout.
REQ-027 Rising edges of sd_clk SHALL have no effect.

Reset
REQ-028 On reset assertion, immediately: state IDLE, ready=1, done=0, cmd_oe=0, cmd_out=1, bit/trailer counters 0, CRC 0, sd_clk history register 0.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; CMD released in the same cycle reset is seen.
REQ-030 After reset release, the first fall event SHALL require sd_clk observed high then low after release.

Verification
REQ-031 CMD0, argument 0x00000000 -> serial bits equal 0x400000000095, cmd_oe high for exactly 48 sd_clk periods, then done after 8 fall events.
REQ-032 CMD8, argument 0x000001AA -> frame 0x48000001AA87.
REQ-033 CMD17, argument 0x00000000 -> frame 0x510000000055; CMD55, argument 0 -> 0x770000000065.
REQ-034 start pulsed repeatedly during SHIFT with differing index/argument -> in-flight frame unchanged, extra starts dropped.
REQ-035 reset asserted at bit 20 of a frame -> cmd_oe=0, cmd_out=1, ready=1 next sample, no done; subsequent CMD0 transmits correctly.
REQ-036 start asserted in the done cycle, divider count 0 and count 3 -> back-to-back frames, each bit lasting exactly one sd_clk period.
